sort_host: RTL and testbench

SORT_HOST -- requirements
Module: sort_host

---
 rtl/sort_pkg.sv | 26 ++
 rtl/sort_host_if.sv | 34 +++
 rtl/sort_buf.sv | 37 +++
 rtl/sort_host.sv | 199 +++++++++++++++++++
 tb/tb_sort_host.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/sort_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sort_pkg                                                             |
// | Shared definitions for the sort host and its sorter: default job     |
// | size, word width and the host state encoding.                        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package sort_pkg;

  localparam int N_DEF = 8;
  localparam int W_DEF = 8;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_FILL    = 4'd1,
    ST_ARM_LD  = 4'd2,
    ST_LOAD    = 4'd3,
    ST_ARM_SRT = 4'd4,
    ST_SORTING = 4'd5,
    ST_ARM_SND = 4'd6,
    ST_DRAIN   = 4'd7,
    ST_EMIT    = 4'd8
  } state_e;

endpackage
`default_nettype wire

// File: rtl/sort_host_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sort_host_if                                                         |
// | User-side word streams of the sort host: an input stream of unsorted |
// | words and an output stream of sorted words, both valid/ready.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface sort_host_if
  import sort_pkg::*;
#(
  parameter int W = W_DEF
) ();

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  // The host side: consumes the input stream, produces the output stream.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  // The user side: produces input words, consumes sorted words.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface
`default_nettype wire

// File: rtl/sort_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sort_buf                                                             |
// | N x W word buffer, one synchronous write port and one combinational  |
// | read port. Out-of-range reads return zero; out-of-range writes are   |
// | dropped. Contents are intentionally not reset.                       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sort_buf #(
  parameter int N  = 8,
  parameter int W  = 8,
  parameter int AW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  localparam int            IW    = (N > 1) ? $clog2(N) : 1;
  localparam logic [AW-1:0] DEPTH = AW'(N);

  logic [W-1:0] mem_q [N];

  // Write port: store one word per enabled cycle at an in-range address.
  always_ff @(posedge clk) begin
    if (we && (waddr < DEPTH)) begin
      mem_q[waddr[IW-1:0]] <= wdata;
    end
  end

  assign rdata = (raddr < DEPTH) ? mem_q[raddr[IW-1:0]] : '0;

endmodule
`default_nettype wire

// File: rtl/sort_host.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sort_host                                                            |
// | Collects N user words, loads them into an external sorter, reads the |
// | sorted words back into the same buffer and streams them out in the   |
// | order the sorter delivered them. Flags sorter protocol violations.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sort_host
  import sort_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  sort_host_if.slave   s_io,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         srt_load,
  output logic         srt_sort,
  output logic         srt_send,
  output logic [W-1:0] srt_wdata,
  input  logic         srt_ready,
  input  logic         srt_busy,
  input  logic         srt_waiting,
  input  logic         srt_ld,
  input  logic         srt_snd,
  input  logic [W-1:0] srt_rdata
);

  localparam int            KW     = $clog2(N + 1);
  localparam logic [KW-1:0] K_N    = KW'(N);
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic          err_q, err_d;
  logic          snd_q, snd_d;
  logic          done_q, done_d;

  logic          buf_we;
  logic [W-1:0]  buf_wdata;
  logic [W-1:0]  buf_rdata;
  logic [KW-1:0] pending;
  logic          snd_ok;
  logic          ld_ok;

  // Sorter busy is informational only; the host keys off ready/waiting.
  logic unused_srt_busy;
  assign unused_srt_busy = srt_busy;

  sort_buf #(.N(N), .W(W), .AW(KW)) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (k_q),
    .wdata (buf_wdata),
    .raddr (k_q),
    .rdata (buf_rdata)
  );

  // A send strobe is legal only in DRAIN while fewer than N words are
  // captured or in flight; a load strobe only in LOAD before k reaches N.
  assign pending = k_q + KW'(snd_q);
  assign snd_ok  = (state_q == ST_DRAIN) && (pending < K_N);
  assign ld_ok   = (state_q == ST_LOAD) && (k_q != K_N);

  // Next-state, counter, error and strobe logic for the job sequence.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    err_d     = err_q;
    done_d    = 1'b0;
    buf_we    = 1'b0;
    buf_wdata = '0;
    srt_load  = 1'b0;
    srt_sort  = 1'b0;
    srt_send  = 1'b0;
    s_io.in_ready  = 1'b0;
    s_io.out_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FILL;
          k_d     = '0;
          err_d   = 1'b0;
        end
      end
      ST_FILL: begin
        s_io.in_ready = 1'b1;
        if (s_io.in_valid) begin
          buf_we    = 1'b1;
          buf_wdata = s_io.in_data;
          if (k_q == K_LAST) begin
            state_d = ST_ARM_LD;
            k_d     = '0;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      ST_ARM_LD: begin
        if (srt_ready) begin
          srt_load = 1'b1;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (srt_ld && (k_q != K_N)) begin
          k_d = k_q + 1'b1;
        end
        if ((k_q == K_N) && srt_ready) begin
          state_d = ST_ARM_SRT;
        end
      end
      ST_ARM_SRT: begin
        if (srt_ready) begin
          srt_sort = 1'b1;
          state_d  = ST_SORTING;
          k_d      = '0;
        end
      end
      ST_SORTING: begin
        if (srt_waiting) begin
          state_d = ST_ARM_SND;
        end
      end
      ST_ARM_SND: begin
        srt_send = 1'b1;
        state_d  = ST_DRAIN;
      end
      ST_DRAIN: begin
        // srt_rdata is valid the cycle after srt_snd, hence the registered strobe.
        if (snd_q) begin
          buf_we    = 1'b1;
          buf_wdata = srt_rdata;
          if (k_q == K_LAST) begin
            state_d = ST_EMIT;
            k_d     = '0;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      ST_EMIT: begin
        s_io.out_valid = 1'b1;
        if (s_io.out_ready) begin
          if (k_q == K_LAST) begin
            state_d = ST_IDLE;
            k_d     = '0;
            done_d  = 1'b1;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        k_d     = '0;
      end
    endcase

    snd_d = srt_snd && snd_ok;
    if (srt_ld && !ld_ok) begin
      err_d = 1'b1;
    end
    if (srt_snd && !snd_ok) begin
      err_d = 1'b1;
    end
  end

  // State register; reset returns to IDLE but leaves the buffer intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      err_q   <= 1'b0;
      snd_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      err_q   <= err_d;
      snd_q   <= snd_d;
      done_q  <= done_d;
    end
  end

  assign srt_wdata     = ld_ok ? buf_rdata : '0;
  assign s_io.out_data = (state_q == ST_EMIT) ? buf_rdata : '0;
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign err           = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sort_host.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sort_host                                                         |
// | Directed self-checking bench for sort_host with a behavioural sorter |
// | model. N=4, W=8.                                                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_sort_host;

  localparam int N = 4;
  localparam int W = 8;

  localparam int M_IDLE = 0;
  localparam int M_LD   = 1;
  localparam int M_WS   = 2;
  localparam int M_SORT = 3;
  localparam int M_WAIT = 4;
  localparam int M_SND  = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, busy, done, err;
  logic         srt_load, srt_sort, srt_send;
  logic [W-1:0] srt_wdata;
  logic         srt_ready, srt_busy, srt_waiting, srt_ld, srt_snd;
  logic [W-1:0] srt_rdata;

  sort_host_if #(.W(W)) u_if ();

  sort_host #(.N(N), .W(W)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .s_io        (u_if),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .srt_load    (srt_load),
    .srt_sort    (srt_sort),
    .srt_send    (srt_send),
    .srt_wdata   (srt_wdata),
    .srt_ready   (srt_ready),
    .srt_busy    (srt_busy),
    .srt_waiting (srt_waiting),
    .srt_ld      (srt_ld),
    .srt_snd     (srt_snd),
    .srt_rdata   (srt_rdata)
  );

  int           n_checks = 0;
  int           n_fail   = 0;
  int           done_cnt = 0;
  int           sm;
  int           cnt;
  bit           extra_ld, extra_done, model_rst;
  logic [W-1:0] ld_seen [N];
  logic [W-1:0] sorted  [N];
  logic [W-1:0] in_w    [N];
  logic [W-1:0] exp_w   [N];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_vec(input logic [31:0] a, input logic [31:0] e);
    for (int i = 0; i < N; i++) begin
      in_w[i]  = a[31-8*i -: 8];
      exp_w[i] = e[31-8*i -: 8];
    end
  endtask

  // Behavioural sorter, stepping on the falling edge.
  initial begin
    srt_ready = 1'b1; srt_busy = 1'b0; srt_waiting = 1'b0;
    srt_ld = 1'b0; srt_snd = 1'b0; srt_rdata = '0;
    sm = M_IDLE; cnt = 0; extra_done = 1'b0;
    forever begin
      @(negedge clk);
      if (model_rst) begin
        srt_ready = 1'b1; srt_busy = 1'b0; srt_waiting = 1'b0;
        srt_ld = 1'b0; srt_snd = 1'b0; srt_rdata = '0; sm = M_IDLE;
      end else begin
        case (sm)
          M_IDLE: if (srt_load) begin cnt = 0; extra_done = 1'b0; sm = M_LD; end
          M_LD: begin
            srt_ready = 1'b0;
            if (cnt < N) begin
              srt_ld = 1'b1; ld_seen[cnt] = srt_wdata; cnt++;
            end else if (extra_ld && !extra_done) begin
              srt_ld = 1'b1; extra_done = 1'b1;
            end else begin
              srt_ld = 1'b0; srt_ready = 1'b1; sm = M_WS;
            end
          end
          M_WS: if (srt_sort) begin
            for (int i = 0; i < N; i++) sorted[i] = ld_seen[i];
            for (int i = 0; i < N - 1; i++)
              for (int j = 0; j < N - 1 - i; j++)
                if (sorted[j] > sorted[j+1]) begin
                  logic [W-1:0] tmp;
                  tmp = sorted[j]; sorted[j] = sorted[j+1]; sorted[j+1] = tmp;
                end
            cnt = 0; sm = M_SORT;
          end
          M_SORT: begin
            srt_ready = 1'b0; srt_busy = 1'b1; cnt++;
            if (cnt == 3) begin srt_busy = 1'b0; srt_waiting = 1'b1; sm = M_WAIT; end
          end
          M_WAIT: if (srt_send) begin srt_waiting = 1'b0; cnt = 0; sm = M_SND; end
          M_SND: begin
            srt_snd = (cnt < N);
            if (cnt > 0) srt_rdata = sorted[cnt-1];
            if (cnt == N) begin srt_ready = 1'b1; sm = M_IDLE; end
            cnt++;
          end
          default: sm = M_IDLE;
        endcase
      end
    end
  end

  // Count done pulses as seen mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic run_job(input string nm, input int stall_idx, input bit extra,
                         input bit drain_start, input bit rst_in_sort);
    int t;
    int d0;
    extra_ld = extra;
    d0 = done_cnt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({nm, "_err_clr"}, err, 0);
    chk({nm, "_busy"}, busy, 1);
    for (int i = 0; i < N; i++) begin
      u_if.in_valid = 1'b1; u_if.in_data = in_w[i];
      t = 0;
      while (!u_if.in_ready && t < 50) begin @(negedge clk); t++; end
      chk({nm, "_in_ready"}, u_if.in_ready, 1);
      @(negedge clk);
    end
    u_if.in_valid = 1'b0; u_if.in_data = '0;
    if (rst_in_sort) begin
      t = 0;
      while (sm != M_SORT && t < 200) begin @(negedge clk); t++; end
      chk({nm, "_reach_sort"}, (sm == M_SORT), 1);
      @(negedge clk); rst = 1'b1; model_rst = 1'b1;
      @(negedge clk);
      chk({nm, "_rst_busy"}, busy, 0);
      chk({nm, "_rst_strobes"}, {srt_load, srt_sort, srt_send}, 0);
      chk({nm, "_rst_wdata"}, srt_wdata, 0);
      chk({nm, "_rst_hs"}, {u_if.in_ready, u_if.out_valid, done, err}, 0);
      rst = 1'b0; model_rst = 1'b0;
      return;
    end
    if (drain_start) begin
      t = 0;
      while (sm != M_SND && t < 200) begin @(negedge clk); t++; end
      chk({nm, "_reach_drain"}, (sm == M_SND), 1);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk({nm, "_busy_drain"}, busy, 1);
    end
    for (int i = 0; i < N; i++) begin
      u_if.out_ready = 1'b1;
      t = 0;
      while (!u_if.out_valid && t < 300) begin @(negedge clk); t++; end
      chk({nm, "_out_valid"}, u_if.out_valid, 1);
      if (i == stall_idx) begin
        u_if.out_ready = 1'b0;
        repeat (3) begin
          chk({nm, "_hold_valid"}, u_if.out_valid, 1);
          chk({nm, "_hold_data"}, u_if.out_data, exp_w[i]);
          @(negedge clk);
        end
        u_if.out_ready = 1'b1;
      end
      chk({nm, $sformatf("_out%0d", i)}, u_if.out_data, exp_w[i]);
      @(negedge clk);
    end
    u_if.out_ready = 1'b0;
    chk({nm, "_done"}, done, 1);
    chk({nm, "_idle"}, busy, 0);
    @(negedge clk);
    chk({nm, "_done_drop"}, done, 0);
    chk({nm, "_done_cnt"}, done_cnt - d0, 1);
    for (int i = 0; i < N; i++) chk({nm, $sformatf("_wdata%0d", i)}, ld_seen[i], in_w[i]);
    chk({nm, "_err_end"}, err, {31'd0, extra});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; model_rst = 1'b0; extra_ld = 1'b0;
    u_if.in_valid = 1'b0; u_if.in_data = '0; u_if.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {done, err}, 0);
    chk("rst_hs", {u_if.in_ready, u_if.out_valid}, 0);
    chk("rst_strobes", {srt_load, srt_sort, srt_send}, 0);
    chk("rst_wdata", srt_wdata, 0);
    rst = 1'b0;

    set_vec(32'h03010402, 32'h01020304); run_job("basic", -1, 1'b0, 1'b0, 1'b0);
    set_vec(32'hFF0000FF, 32'h0000FFFF); run_job("dup",   -1, 1'b0, 1'b0, 1'b0);
    set_vec(32'h050A0107, 32'h0105070A); run_job("stall",  1, 1'b0, 1'b0, 1'b0);
    set_vec(32'h03010402, 32'h01020304); run_job("xld",   -1, 1'b1, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    chk("xld_err_sticky", err, 1);
    set_vec(32'h11223344, 32'h11223344); run_job("rstsort", -1, 1'b0, 1'b0, 1'b1);
    set_vec(32'h09080706, 32'h06070809); run_job("after_rst", -1, 1'b0, 1'b0, 1'b0);
    set_vec(32'h1E0A2814, 32'h0A141E28); run_job("drain_start", -1, 1'b0, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    chk("final_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
